// File: rtl/ps2_scan_decoder.sv
// PS/2 set-2 scan-code decoder: folds E0/F0/E1 prefixes into make/release
// events, tracks shift state, and queues events in a first-word-fall-through FIFO.
// Latency: event visible on EVT_VALID one cycle after its final byte is accepted.
// Backpressure: EVT_READY stalls the FIFO head; a push into a full FIFO without a
// simultaneous pop drops the event and sets the sticky OVERFLOW flag.
//
// Ports:
//   CLK, RST                 clock, asynchronous active-high reset
//   CODE_VALID/CODE/CODE_ERR byte strobe, scan-code byte, framing/parity error
//   EVT_READY                consumer accepts the head event
//   EVT_VALID/CODE/EXT/REL/SHIFT  head event (fields zero while FIFO empty)
//   OVERFLOW                 sticky: an event was dropped
module ps2_scan_decoder #(
   parameter int FIFO_DEPTH     = 4,
   parameter int PREFIX_TIMEOUT = 1000000
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       CODE_VALID,
   input  logic [7:0] CODE,
   input  logic       CODE_ERR,
   input  logic       EVT_READY,
   output logic       EVT_VALID,
   output logic [7:0] EVT_CODE,
   output logic       EVT_EXT,
   output logic       EVT_REL,
   output logic       EVT_SHIFT,
   output logic       OVERFLOW
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int TW = (PREFIX_TIMEOUT > 1) ? $clog2(PREFIX_TIMEOUT) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(PREFIX_TIMEOUT - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      IDLE,
      EXT,
      BRK,
      EXT_BRK,
      SKIP
   } state_t;

   typedef struct packed {
      logic [7:0] code;
      logic       ext;
      logic       rel;
      logic       shift;
   } evt_t;

   state_t          state;
   logic [2:0]      skip_cnt;
   logic [TW-1:0]   tmo_cnt;
   logic            shift_l;
   logic            shift_r;

   logic            byte_acc;
   logic            byte_err;
   logic            is_noise;
   logic            is_prefix;

   logic            gen;
   logic            gen_ext;
   logic            gen_rel;
   logic            shift_l_nxt;
   logic            shift_r_nxt;
   evt_t            new_evt;

   evt_t            mem [FIFO_DEPTH];
   logic [AW-1:0]   rd_ptr;
   logic [AW-1:0]   wr_ptr;
   logic [CW-1:0]   count;
   logic            full;
   logic            pop;
   logic            push_ok;
   evt_t            head;

   assign byte_acc  = CODE_VALID & ~CODE_ERR;
   assign byte_err  = CODE_VALID & CODE_ERR;
   assign is_prefix = (CODE == 8'hE0) || (CODE == 8'hF0);
   // Controller responses (ACK, BAT, echo, resend, errors) carry no key info
   assign is_noise  = (CODE == 8'h00) || (CODE == 8'hAA) || (CODE == 8'hEE) ||
                      (CODE == 8'hFA) || (CODE == 8'hFE) || (CODE == 8'hFF);

   // Event decode for the byte accepted this cycle
   always_comb begin
      gen     = 1'b0;
      gen_ext = 1'b0;
      gen_rel = 1'b0;
      if (byte_acc) begin
         case (state)
            IDLE: begin
               if (!is_prefix && CODE != 8'hE1 && !is_noise) gen = 1'b1;
            end
            EXT: begin
               if (!is_prefix) begin
                  gen     = 1'b1;
                  gen_ext = 1'b1;
               end
            end
            BRK: begin
               if (!is_prefix) begin
                  gen     = 1'b1;
                  gen_rel = 1'b1;
               end
            end
            EXT_BRK: begin
               if (!is_prefix) begin
                  gen     = 1'b1;
                  gen_ext = 1'b1;
                  gen_rel = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Shift flags as updated by this event, so a shift make reports 1 itself
   always_comb begin
      shift_l_nxt = shift_l;
      shift_r_nxt = shift_r;
      if (gen && !gen_ext && CODE == 8'h12) shift_l_nxt = ~gen_rel;
      if (gen && !gen_ext && CODE == 8'h59) shift_r_nxt = ~gen_rel;
   end

   assign new_evt = '{code: CODE, ext: gen_ext, rel: gen_rel,
                      shift: shift_l_nxt | shift_r_nxt};

   // Prefix FSM with skip and timeout counters
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state    <= IDLE;
         skip_cnt <= '0;
         tmo_cnt  <= '0;
      end else if (byte_err) begin
         state    <= IDLE;
         skip_cnt <= '0;
         tmo_cnt  <= '0;
      end else if (byte_acc) begin
         tmo_cnt <= '0;
         case (state)
            IDLE: begin
               if (CODE == 8'hE0) begin
                  state <= EXT;
               end else if (CODE == 8'hF0) begin
                  state <= BRK;
               end else if (CODE == 8'hE1) begin
                  // Pause: E1 followed by seven more bytes, none reported
                  state    <= SKIP;
                  skip_cnt <= 3'd7;
               end
            end
            EXT: begin
               if (CODE == 8'hF0)      state <= EXT_BRK;
               else if (CODE != 8'hE0) state <= IDLE;
            end
            BRK, EXT_BRK: begin
               state <= IDLE;
            end
            SKIP: begin
               if (skip_cnt == 3'd1) begin
                  state    <= IDLE;
                  skip_cnt <= '0;
               end else begin
                  skip_cnt <= skip_cnt - 3'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end else if (state != IDLE) begin
         if (tmo_cnt == TMO_LAST) begin
            state    <= IDLE;
            skip_cnt <= '0;
            tmo_cnt  <= '0;
         end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
         end
      end else begin
         tmo_cnt <= '0;
      end
   end

   // Shift flags commit even if the event itself is dropped by a full FIFO
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         shift_l <= 1'b0;
         shift_r <= 1'b0;
      end else begin
         shift_l <= shift_l_nxt;
         shift_r <= shift_r_nxt;
      end
   end

   // Event FIFO
   assign EVT_VALID = (count != '0);
   assign full      = (count == CNT_FULL);
   assign pop       = EVT_VALID & EVT_READY;
   // A pop in the same cycle frees the slot the push needs
   assign push_ok   = gen & (~full | pop);

   always_ff @(posedge CLK) begin
      if (push_ok) mem[wr_ptr] <= new_evt;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         OVERFLOW <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         if (push_ok && !pop)      count <= count + 1'b1;
         else if (!push_ok && pop) count <= count - 1'b1;
         if (gen && full && !pop) OVERFLOW <= 1'b1;
      end
   end

   // Memory is not reset, so the head is masked while the FIFO is empty
   assign head      = EVT_VALID ? mem[rd_ptr] : '0;
   assign EVT_CODE  = head.code;
   assign EVT_EXT   = head.ext;
   assign EVT_REL   = head.rel;
   assign EVT_SHIFT = head.shift;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Testbench for ps2_scan_decoder: reference decoder predicts events into a
// scoreboard queue; a negedge monitor compares the DUT FIFO head against it.
module tb_ps2_scan_decoder;

   localparam int DEPTH = 4;
   localparam int TMO   = 32;

   logic       CLK = 1'b0;
   logic       RST;
   logic       CODE_VALID;
   logic [7:0] CODE;
   logic       CODE_ERR;
   logic       EVT_READY;
   logic       EVT_VALID;
   logic [7:0] EVT_CODE;
   logic       EVT_EXT;
   logic       EVT_REL;
   logic       EVT_SHIFT;
   logic       OVERFLOW;

   ps2_scan_decoder #(.FIFO_DEPTH(DEPTH), .PREFIX_TIMEOUT(TMO)) dut (
      .CLK(CLK), .RST(RST), .CODE_VALID(CODE_VALID), .CODE(CODE),
      .CODE_ERR(CODE_ERR), .EVT_READY(EVT_READY), .EVT_VALID(EVT_VALID),
      .EVT_CODE(EVT_CODE), .EVT_EXT(EVT_EXT), .EVT_REL(EVT_REL),
      .EVT_SHIFT(EVT_SHIFT), .OVERFLOW(OVERFLOW)
   );

   always #5 CLK = ~CLK;

   int tests = 0;
   int fails = 0;
   bit running = 0;

   // Scoreboard entries: {code, ext, rel, shift}
   logic [10:0] sb[$];
   int  occ = 0;
   bit  exp_ovf = 0;

   // Reference decoder state: pending prefix, skip bytes left, shift keys held
   bit  m_ext = 0, m_brk = 0, sh_l = 0, sh_r = 0;
   int  m_skip = 0;
   int  cyc = 0, m_last = 0;

   task automatic model_clear();
      m_ext = 0; m_brk = 0; m_skip = 0; sh_l = 0; sh_r = 0;
      occ = 0; exp_ovf = 0;
      sb.delete();
   endtask

   task automatic model_byte(input logic [7:0] b, input logic err,
                             output bit has, output logic [10:0] e);
      bit ext = 0, rel = 0;
      has = 0;
      e = '0;
      // A prefix left waiting more than TMO cycles is forgotten
      if ((m_ext || m_brk || m_skip > 0) && (cyc - m_last) > TMO) begin
         m_ext = 0; m_brk = 0; m_skip = 0;
      end
      if (err) begin
         m_ext = 0; m_brk = 0; m_skip = 0;
         return;
      end
      m_last = cyc;
      if (m_skip > 0) begin
         m_skip--;
         return;
      end
      if (m_brk) begin
         if (b != 8'hE0 && b != 8'hF0) begin
            has = 1; ext = m_ext; rel = 1;
         end
         m_ext = 0; m_brk = 0;
      end else if (m_ext) begin
         if (b == 8'hF0) m_brk = 1;
         else if (b != 8'hE0) begin
            has = 1; ext = 1; m_ext = 0;
         end
      end else begin
         case (b)
            8'hE0: m_ext = 1;
            8'hF0: m_brk = 1;
            8'hE1: m_skip = 7;
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: ;
            default: has = 1;
         endcase
      end
      if (has) begin
         if (!ext && b == 8'h12) sh_l = !rel;
         if (!ext && b == 8'h59) sh_r = !rel;
         e = {b, ext, rel, sh_l | sh_r};
      end
   endtask

   // Predict FIFO contents from the byte stream and the bench's own READY
   always @(posedge CLK) begin
      bit          has;
      bit          pop;
      logic [10:0] e;
      if (RST) begin
         model_clear();
      end else begin
         cyc++;
         pop = (occ > 0) && EVT_READY;
         has = 0;
         if (CODE_VALID) model_byte(CODE, CODE_ERR, has, e);
         if (has) begin
            if (occ < DEPTH || pop) begin
               sb.push_back(e);
               occ++;
            end else begin
               exp_ovf = 1;
            end
         end
         if (pop) occ--;
      end
   end

   // Monitor
   always @(negedge CLK) begin
      logic [10:0] got;
      if (running && !RST) begin
         tests++;
         if (EVT_VALID !== (sb.size() != 0)) begin
            fails++;
            $display("FAIL evt_valid t=%0t: got %0b expected %0b", $time, EVT_VALID, sb.size() != 0);
         end else if (EVT_VALID) begin
            got = {EVT_CODE, EVT_EXT, EVT_REL, EVT_SHIFT};
            tests++;
            if (got !== sb[0]) begin
               fails++;
               $display("FAIL evt_head t=%0t: got code=%h ext=%b rel=%b sh=%b expected code=%h ext=%b rel=%b sh=%b",
                        $time, got[10:3], got[2], got[1], got[0], sb[0][10:3], sb[0][2], sb[0][1], sb[0][0]);
            end
            if (EVT_READY) void'(sb.pop_front());
         end
         tests++;
         if (OVERFLOW !== exp_ovf) begin
            fails++;
            $display("FAIL overflow t=%0t: got %0b expected %0b", $time, OVERFLOW, exp_ovf);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Drivers: called at posedge+1, each byte occupies one cycle
   task automatic send(input logic [7:0] b, input logic err = 1'b0);
      CODE_VALID = 1'b1;
      CODE       = b;
      CODE_ERR   = err;
      @(posedge CLK); #1;
      CODE_VALID = 1'b0;
      CODE_ERR   = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge CLK); #1;
      end
   endtask

   task automatic send_seq(input logic [7:0] s[$]);
      foreach (s[i]) send(s[i]);
   endtask

   task automatic do_reset(input string name);
      RST = 1'b1;
      sb.delete();
      occ = 0;
      #1;
      chk({name, "_valid"}, 32'(EVT_VALID), 0);
      chk({name, "_code"}, 32'(EVT_CODE), 0);
      chk({name, "_ovf"}, 32'(OVERFLOW), 0);
      @(posedge CLK); #1;
      RST = 1'b0;
   endtask

   function automatic logic [7:0] pick_byte();
      logic [7:0] noise [6] = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
      case ($urandom_range(0, 15))
         0, 1:    return 8'hE0;
         2, 3:    return 8'hF0;
         4:       return 8'hE1;
         5:       return noise[$urandom_range(0, 5)];
         6, 7:    return 8'h12;
         8, 9:    return 8'h59;
         default: return 8'($urandom_range(0, 255));
      endcase
   endfunction

   initial begin
      RST        = 1'b1;
      CODE_VALID = 1'b0;
      CODE       = 8'h00;
      CODE_ERR   = 1'b0;
      EVT_READY  = 1'b1;
      #3;
      chk("reset_valid", 32'(EVT_VALID), 0);
      chk("reset_code",  32'(EVT_CODE), 0);
      chk("reset_ext",   32'(EVT_EXT), 0);
      chk("reset_rel",   32'(EVT_REL), 0);
      chk("reset_shift", 32'(EVT_SHIFT), 0);
      chk("reset_ovf",   32'(OVERFLOW), 0);
      @(posedge CLK); @(posedge CLK); #1;
      RST = 1'b0;
      running = 1;

      // Make then release of a plain key
      send_seq('{8'h1C, 8'hF0, 8'h1C});
      idle(3);
      // Extended make/release; extended 12 is not a shift key
      send_seq('{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'hE0, 8'h12});
      idle(3);
      // Two shift keys overlapping
      send_seq('{8'h12, 8'h1C, 8'h59, 8'hF0, 8'h12, 8'h1C, 8'hF0, 8'h59});
      idle(3);

      // Fill the FIFO with the consumer stalled, then overflow
      EVT_READY = 1'b0;
      send_seq('{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C});
      idle(2);
      chk("ovf_after_fill", 32'(OVERFLOW), 1);
      // Full FIFO with push and pop together: nothing dropped
      EVT_READY = 1'b1;
      send(8'h35);
      idle(8);

      // Pause sequence swallowed
      send_seq('{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h1C});
      idle(3);
      // Prefix timeout, both sides of the boundary
      send(8'hE0); idle(TMO + 2); send(8'h1C); idle(2);
      send(8'hF0); idle(TMO - 1); send(8'h1C); idle(2);
      send(8'hF0); idle(TMO);     send(8'h1C); idle(2);

      // Errored byte after F0 cancels the release
      send(8'hF0); send(8'h1C, 1'b1); send(8'h1C);
      idle(3);

      // Reset with events queued, then reset after a bare prefix
      EVT_READY = 1'b0;
      send_seq('{8'h1C, 8'h32});
      do_reset("rst_queued");
      EVT_READY = 1'b1;
      send(8'hE0);
      do_reset("rst_prefix");
      send(8'h75);
      idle(3);

      // Randomized traffic
      for (int n = 0; n < 1500; n++) begin
         int r;
         EVT_READY = ($urandom_range(0, 3) != 0);
         send(pick_byte(), ($urandom_range(0, 40) == 0));
         r = $urandom_range(0, 99);
         if (r < 60)      ;
         else if (r < 95) idle($urandom_range(1, 4));
         else             idle($urandom_range(TMO - 2, TMO + 2));
         if ($urandom_range(0, 299) == 0) do_reset("rst_random");
      end

      // Drain, bounded
      EVT_READY = 1'b1;
      for (int i = 0; i < 50 && sb.size() != 0; i++) begin
         @(posedge CLK); #1;
      end
      chk("drain_empty", 32'(sb.size()), 0);
      @(negedge CLK);
      running = 0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
